// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FPU dispatch slice.
package fpu_pkg;

    typedef enum logic {
        FADD = 1'b0,
        FSUB = 1'b1
    } fpu_op_e;

    localparam int FADD_LAT = 3;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
    } res_entry_t;

endpackage

// File: rtl/fpu_dispatch_if.sv
// fpu_dispatch_if: request, adder issue/return and result handshakes.
interface fpu_dispatch_if;
    import fpu_pkg::*;

    logic        req_valid;
    logic        req_ready;
    fpu_op_e     req_op;
    logic [31:0] req_x1;
    logic [31:0] req_x2;
    logic [4:0]  req_rd;

    logic        fadd_valid;
    logic [31:0] fadd_x1;
    logic [31:0] fadd_x2;
    logic [31:0] fadd_y;
    logic        fadd_out_valid;

    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_rd;

    modport master (
        input  req_valid, req_op, req_x1, req_x2, req_rd,
        output req_ready,
        output fadd_valid, fadd_x1, fadd_x2,
        input  fadd_y, fadd_out_valid,
        output res_valid, res_data, res_rd,
        input  res_ready
    );

    modport slave (
        output req_valid, req_op, req_x1, req_x2, req_rd,
        input  req_ready,
        input  fadd_valid, fadd_x1, fadd_x2,
        output fadd_y, fadd_out_valid,
        input  res_valid, res_data, res_rd,
        output res_ready
    );

endinterface

// File: rtl/fpu_res_fifo.sv
// fpu_res_fifo: first-word-fall-through result buffer, DEPTH entries.
module fpu_res_fifo
    import fpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  res_entry_t    wr_data,
    input  logic          rd_en,
    output logic          rd_valid,
    output res_entry_t    rd_data,
    output logic [CW-1:0] count
);

    res_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full/empty guards keep the buffer safe even if a caller misbehaves.
    assign push = wr_en & (count_q != CW'(DEPTH));
    assign pop  = rd_en & (count_q != '0);

    always_comb begin
        wr_ptr_d = push ? bump(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? bump(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/fpu_dispatch.sv
// fpu_dispatch: issues FADD/FSUB to a fixed-latency adder, returns results in order.
// Define FPU_DISPATCH_PERF_EN to add the perf_issued / perf_stall counters.
module fpu_dispatch
    import fpu_pkg::*;
#(
    parameter int LAT   = FADD_LAT,
    parameter int DEPTH = 4
) (
    input  logic           sys_clk,
    input  logic           rst,
    fpu_dispatch_if.master bus,
    output logic           err
`ifdef FPU_DISPATCH_PERF_EN
    ,
    output logic [31:0]    perf_issued,
    output logic [31:0]    perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(LAT + 1);

    logic [LAT-1:0]      tag_v_q, tag_v_d;
    logic [LAT-1:0][4:0] tag_rd_q, tag_rd_d;
    logic [CW-1:0]       inflight_q, inflight_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic                err_q, err_d;

    logic          fire, ready, drained, tag_out, pop, fifo_valid;
    logic [CW:0]   occ;
    logic [CW-1:0] fifo_count;
    res_entry_t    fifo_wr, fifo_rd;

    // Credit uses registered counts only, so a same-cycle pop frees nothing yet.
    assign drained = (drain_q == '0);
    assign tag_out = tag_v_q[LAT-1];
    assign occ     = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign ready   = ~rst & drained & (occ < (CW + 1)'(DEPTH));
    assign fire    = bus.req_valid & ready;

    assign bus.req_ready  = ready;
    assign bus.fadd_valid = fire;
    assign bus.fadd_x1    = bus.req_x1;
    assign bus.fadd_x2    = {bus.req_x2[31] ^ (bus.req_op == FSUB),
                             bus.req_x2[30:0]};

    always_comb begin
        tag_v_d     = tag_v_q;
        tag_rd_d    = tag_rd_q;
        tag_v_d[0]  = fire;
        tag_rd_d[0] = bus.req_rd;
        for (int i = 1; i < LAT; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_rd_d[i] = tag_rd_q[i-1];
        end
        inflight_d = inflight_q + CW'(fire) - CW'(tag_out);
        drain_d    = drained ? drain_q : drain_q - DW'(1);
        // The adder is not reset, so its strobe is meaningless until drained.
        err_d      = err_q | (drained & (bus.fadd_out_valid != tag_out));
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tag_v_q    <= '0;
            tag_rd_q   <= '0;
            inflight_q <= '0;
            drain_q    <= DW'(LAT);
            err_q      <= 1'b0;
        end else begin
            tag_v_q    <= tag_v_d;
            tag_rd_q   <= tag_rd_d;
            inflight_q <= inflight_d;
            drain_q    <= drain_d;
            err_q      <= err_d;
        end
    end

    assign fifo_wr = {bus.fadd_y, tag_rd_q[LAT-1]};

    fpu_res_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (rst),
        .wr_en   (tag_out),
        .wr_data (fifo_wr),
        .rd_en   (pop),
        .rd_valid(fifo_valid),
        .rd_data (fifo_rd),
        .count   (fifo_count)
    );

    assign bus.res_valid = fifo_valid & ~rst;
    assign pop           = bus.res_valid & bus.res_ready;
    assign bus.res_data  = fifo_rd.data;
    assign bus.res_rd    = fifo_rd.rd;
    assign err           = err_q & ~rst;

`ifdef FPU_DISPATCH_PERF_EN
    logic [31:0] issued_q, issued_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        issued_d = issued_q;
        stall_d  = stall_q;
        if (fire && issued_q != '1) issued_d = issued_q + 32'd1;
        if (bus.req_valid && !ready && stall_q != '1) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign perf_issued = issued_q;
    assign perf_stall  = stall_q;
`endif

endmodule
